// File: rtl/seg7_pattern_capture.sv
// Glitch-filtered 7-segment receiver: registers the segment bus, commits patterns stable for STABLE_CYCLES
// samples, decodes them to {dp,dash,hex} and queues them in a show-ahead FIFO. SEG7_ACTIVE_LOW_EN inverts seg_in.
module seg7_pattern_capture #(
    parameter int STABLE_CYCLES = 4,
    parameter int DEPTH         = 4
) (
    input  logic       clk_2,
    input  logic       reset,
    input  logic [7:0] seg_in,
    input  logic       rd_en,
    output logic [5:0] data_out,
    output logic       empty,
    output logic       full,
    output logic [4:0] count,
    output logic       invalid,
    output logic       overflow
);

    localparam int             CW      = $clog2(STABLE_CYCLES);
    localparam int             AW      = $clog2(DEPTH);
    localparam logic [CW-1:0]  CNT_MAX = CW'(STABLE_CYCLES - 1);
    localparam logic [4:0]     DEPTH_C = 5'(DEPTH);

    logic [7:0]    seg_eff;
    logic [7:0]    sample_q, sample_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          armed_q, armed_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [4:0]    count_q, count_d;
    logic          overflow_q, overflow_d;
    logic [5:0]    mem_q [DEPTH];
    logic [5:0]    mem_d [DEPTH];

    logic          changed, commit;
    logic [3:0]    hex;
    logic          is_digit, is_dash, is_blank;
    logic [5:0]    entry;
    logic          push_req, push_ok, pop;

`ifdef SEG7_ACTIVE_LOW_EN
    assign seg_eff = ~seg_in;
`else
    assign seg_eff = seg_in;
`endif

    // The counter compares each new sample against the one already held, so a
    // pattern is committed STABLE_CYCLES samples after it first appears.
    always_comb begin
        sample_d = seg_eff;
        changed  = (seg_eff != sample_q);
        commit   = armed_q && (cnt_q == CNT_MAX);
        if (changed) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
        if (changed) begin
            armed_d = 1'b1;
        end else if (commit) begin
            armed_d = 1'b0;
        end else begin
            armed_d = armed_q;
        end
    end

    always_comb begin
        hex      = 4'h0;
        is_digit = 1'b1;
        is_dash  = 1'b0;
        is_blank = 1'b0;
        case (sample_q[6:0])
            7'b0111111: hex = 4'h0;
            7'b0000110: hex = 4'h1;
            7'b1011011: hex = 4'h2;
            7'b1001111: hex = 4'h3;
            7'b1100110: hex = 4'h4;
            7'b1101101: hex = 4'h5;
            7'b1111101: hex = 4'h6;
            7'b0000111: hex = 4'h7;
            7'b1111111: hex = 4'h8;
            7'b1101111: hex = 4'h9;
            7'b1110111: hex = 4'hA;
            7'b1111100: hex = 4'hB;
            7'b0111001: hex = 4'hC;
            7'b1011110: hex = 4'hD;
            7'b1111001: hex = 4'hE;
            7'b1110001: hex = 4'hF;
            7'b1000000: begin
                is_digit = 1'b0;
                is_dash  = 1'b1;
            end
            7'b0000000: begin
                is_digit = 1'b0;
                is_blank = 1'b1;
            end
            default:    is_digit = 1'b0;
        endcase
        entry    = {sample_q[7], is_dash, hex};
        push_req = commit && (is_digit || is_dash);
        invalid  = commit && !is_digit && !is_dash && !is_blank;
    end

    // A pop frees a slot in the same cycle, so a full FIFO still accepts a push alongside a read.
    always_comb begin
        mem_d      = mem_q;
        pop        = rd_en && (count_q != 5'd0);
        push_ok    = push_req && ((count_q != DEPTH_C) || pop);
        overflow_d = overflow_q || (push_req && !push_ok);
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = entry;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (push_ok && !pop) begin
            count_d = count_q + 5'd1;
        end else if (pop && !push_ok) begin
            count_d = count_q - 5'd1;
        end
    end

    always_ff @(posedge clk_2) begin
        if (reset) begin
            sample_q   <= '0;
            cnt_q      <= '0;
            armed_q    <= 1'b1;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            sample_q   <= sample_d;
            cnt_q      <= cnt_d;
            armed_q    <= armed_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            mem_q      <= mem_d;
        end
    end

    assign empty    = (count_q == 5'd0);
    assign full     = (count_q == DEPTH_C);
    assign count    = count_q;
    assign overflow = overflow_q;
    assign data_out = empty ? 6'h00 : mem_q[rd_ptr_q];

endmodule

// File: tb/tb_seg7_pattern_capture.sv
// Scoreboarded bench for seg7_pattern_capture: a run-length reference model predicts each cycle's
// outputs into a queue that an independent monitor drains and compares.
module tb_seg7_pattern_capture;

    localparam int STABLE = 4;
    localparam int DEPTH  = 4;
`ifdef SEG7_ACTIVE_LOW_EN
    localparam logic [7:0] INV_MASK = 8'hFF;
`else
    localparam logic [7:0] INV_MASK = 8'h00;
`endif
    localparam logic [6:0] PAT [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    localparam logic [6:0] BAD [4]  = '{7'h49, 7'h01, 7'h22, 7'h0F};

    typedef struct {
        int         cnt;
        bit         ovf;
        bit         inv;
        bit         hv;
        logic [5:0] head;
        bit         zero;
    } exp_t;

    logic       clk_2 = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] seg_in = 8'h00;
    logic       rd_en = 1'b0;
    logic [5:0] data_out;
    logic       empty, full, invalid, overflow;
    logic [4:0] count;

    int   nassert = 0;
    int   nfail   = 0;
    exp_t chk_q[$];

    logic [5:0] mq[$];
    bit         movf;
    logic [7:0] run_val;
    int         run_len;
    bit         pend_vld;
    logic [5:0] pend;

    seg7_pattern_capture #(.STABLE_CYCLES(STABLE), .DEPTH(DEPTH)) dut (
        .clk_2   (clk_2),
        .reset   (reset),
        .seg_in  (seg_in),
        .rd_en   (rd_en),
        .data_out(data_out),
        .empty   (empty),
        .full    (full),
        .count   (count),
        .invalid (invalid),
        .overflow(overflow)
    );

    always #5 clk_2 = ~clk_2;

    function automatic int decode(input logic [6:0] p);
        for (int i = 0; i < 16; i++) begin
            if (PAT[i] == p) return i;
        end
        if (p == 7'h40) return 16;
        if (p == 7'h00) return 17;
        return -1;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nassert++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model of one rising edge: runs of identical samples commit once when they reach STABLE length.
    task automatic model_edge(input logic [7:0] v, input bit rd, input bit rst);
        exp_t e;
        int   d;
        bit   pop;
        e.inv  = 1'b0;
        e.zero = 1'b0;
        if (rst) begin
            mq.delete();
            movf     = 1'b0;
            run_val  = 8'h00;
            run_len  = 1;
            pend_vld = 1'b0;
            e.zero   = 1'b1;
        end else begin
            pop = rd && (mq.size() > 0);
            if (pop) void'(mq.pop_front());
            if (pend_vld) begin
                if (mq.size() < DEPTH) mq.push_back(pend);
                else movf = 1'b1;
            end
            pend_vld = 1'b0;
            if (v == run_val) begin
                run_len++;
            end else begin
                run_val = v;
                run_len = 1;
            end
            if (run_len == STABLE) begin
                d = decode(v[6:0]);
                if (d >= 0 && d <= 16) begin
                    pend_vld = 1'b1;
                    pend     = {v[7], (d == 16), (d == 16) ? 4'h0 : 4'(d)};
                end else if (d < 0) begin
                    e.inv = 1'b1;
                end
            end
        end
        e.cnt  = mq.size();
        e.ovf  = movf;
        e.hv   = (mq.size() > 0);
        e.head = (mq.size() > 0) ? mq[0] : 6'h00;
        chk_q.push_back(e);
    endtask

    task automatic cyc(input logic [7:0] eff, input bit rd, input bit rst);
        @(negedge clk_2);
        seg_in = eff ^ INV_MASK;
        rd_en  = rd;
        reset  = rst;
        model_edge(eff, rd, rst);
    endtask

    // rd_mode: 0 never read, 1 read on the last cycle only, 2 read every cycle
    task automatic hold(input logic [7:0] eff, input int n, input int rd_mode);
        for (int i = 0; i < n; i++) begin
            cyc(eff, (rd_mode == 2) || (rd_mode == 1 && i == n - 1), 1'b0);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk_2);
            #1;
            if (chk_q.size() > 0) begin
                e = chk_q.pop_front();
                check("count", 32'(count), 32'(e.cnt));
                check("empty", 32'(empty), 32'(e.cnt == 0));
                check("full", 32'(full), 32'(e.cnt == DEPTH));
                check("overflow", 32'(overflow), 32'(e.ovf));
                check("invalid", 32'(invalid), 32'(e.inv));
                if (e.hv) check("data_out", 32'(data_out), 32'(e.head));
                else if (e.zero) check("data_out_reset", 32'(data_out), 32'h0);
            end
        end
    end

    initial begin : driver
        logic [7:0] v;
        logic [7:0] prev;
        int         r;
        repeat (2) cyc(8'h00, 1'b0, 1'b1);
        hold(8'h06, 6, 0);
        hold(8'h00, 2, 2);
        hold(8'h5B, 2, 0);
        hold(8'h7F, 1, 0);
        hold(8'h5B, 6, 0);
        hold(8'h00, 2, 2);
        hold(8'hEF, 6, 0);
        hold(8'h00, 6, 0);
        hold(8'hEF, 6, 0);
        hold(8'h00, 3, 2);
        hold(8'h49, 6, 0);
        hold(8'h40, 6, 0);
        hold(8'h00, 2, 2);
        hold(8'h06, 5, 0);
        hold(8'h5B, 5, 0);
        hold(8'h4F, 5, 0);
        hold(8'h66, 5, 0);
        hold(8'h6D, 5, 0);
        hold(8'h7D, 5, 1);
        hold(8'h7F, 3, 0);
        cyc(8'h7F, 1'b0, 1'b1);
        hold(8'h07, 2, 0);
        cyc(8'h07, 1'b0, 1'b1);
        hold(8'h07, 6, 0);
        hold(8'h00, 2, 2);

        prev = 8'h00;
        for (int s = 0; s < 400; s++) begin
            r = $urandom_range(0, 9);
            if (r <= 5)      v = {1'($urandom_range(0, 1)), PAT[$urandom_range(0, 15)]};
            else if (r == 6) v = {1'($urandom_range(0, 1)), 7'h40};
            else if (r == 7) v = {1'($urandom_range(0, 1)), 7'h00};
            else if (r == 8) v = {1'($urandom_range(0, 1)), BAD[$urandom_range(0, 3)]};
            else             v = prev;
            prev = v;
            for (int i = 0, n = $urandom_range(1, 7); i < n; i++) begin
                cyc(v, ($urandom_range(0, 3) == 0), 1'b0);
            end
            if ($urandom_range(0, 99) == 0) cyc(v, 1'b0, 1'b1);
        end

        repeat (3) @(negedge clk_2);
        nassert++;
        if (chk_q.size() != 0) begin
            nfail++;
            $display("FAIL drain: %0d expectations left unchecked, expected 0", chk_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", nassert, nfail);
        $finish;
    end

endmodule
